controller_input: RTL and testbench
===================================

Name: controller_input

Overview:
Upstream stage of the player logic block. Polls a SNES-style serial gamepad, debounces the button state, and emits one-cycle pressed/released edge pulses. Output is packed as the 10-bit input_data word that the player logic consumes directly. Sits between the top-level controller pins and the player logic block.

Parameters:
HALF_PERIOD, 150, clk cycles per half period of ctrl_clk and per half of the latch pulse (latch is 2*HALF_PERIOD wide)
POLL_PERIOD, 25000, clk cycles between poll starts (must exceed 2*HALF_PERIOD*17)
DEBOUNCE_POLLS, 3, consecutive identical polls needed before the stable state updates (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ctrl_data  in  1  serial data from pad; low = button pressed
ctrl_latch  out  1  latch strobe to pad
ctrl_clk  out  1  shift clock to pad; idles high
input_data  out  10  [9:5] pressed pulses, [4:0] released pulses; bit order within each field: 0=up, 1=down, 2=left, 3=right, 4=attack
ctrl_present  out  1  1 when the last completed poll saw a connected pad
poll_done  out  1  one-cycle pulse when a poll completes

Behaviour:
- Reset is asynchronous and active-low. While reset is low: ctrl_latch=0, ctrl_clk=1, input_data=0, ctrl_present=0, poll_done=0, stable/candidate=0, debounce count=0, FSM=IDLE, poll counter=0.
- After reset deasserts, the first poll starts on the next clk. Each later poll starts POLL_PERIOD cycles after the previous start.
- FSM states: IDLE, LATCH, SHIFT_LO, SHIFT_HI, EVAL.
- IDLE -> LATCH: when the poll counter expires. The counter reloads on the same edge.
- LATCH: ctrl_latch=1 for 2*HALF_PERIOD cycles. Then bit index = 0 and the FSM enters SHIFT_LO.
- Sampling: bit 0 is valid while latch is high. ctrl_data is sampled on the last LATCH cycle.
- SHIFT_LO: ctrl_clk=0 for HALF_PERIOD cycles, then go to SHIFT_HI.
- SHIFT_HI: ctrl_clk=1 for HALF_PERIOD cycles. On its last cycle, sample the next bit. After 16 bits total, go to EVAL.
- Sampled bits: raw[i] = ~ctrl_data (active-high inside the block). SNES order: 0=B, 1=Y, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right, 8=A, 9=X, 10=L, 11=R, 12..15 fixed.
- Mapped sample, 5 bits: up=raw[4], down=raw[5], left=raw[6], right=raw[7], attack=raw[0]|raw[8].
- Presence check: a pad is present iff raw[15:12]==0, i.e. the wire reads high. If absent, the mapped sample is forced to 0, so all buttons read as released.
- EVAL takes one cycle, then returns to IDLE. On this cycle:
  - ctrl_present is updated.
  - poll_done=1.
  - Debounce: if sample==candidate, count saturates at DEBOUNCE_POLLS. Otherwise candidate<=sample and count<=1. When count reaches DEBOUNCE_POLLS, new_stable=candidate; otherwise new_stable=stable.
  - input_data[9:5] = new_stable & ~stable, and input_data[4:0] = ~new_stable & stable, registered on the same edge as the stable update. Both are valid for exactly one cycle, then return to 0.
  - stable <= new_stable.
- Simultaneous events: presses and releases of different buttons in the same poll appear in the same pulse. Opposing directions (e.g. up+down) pass through unfiltered.
- With DEBOUNCE_POLLS=1, edges appear on the first poll showing the change.
- Glitch rejection: a sample that differs for fewer than DEBOUNCE_POLLS polls produces no pulses.
- Reset mid-poll: outputs go to idle immediately and the partial sample is discarded. No pulses are generated for buttons held across reset until after debounce.
- Widths: poll counter is $clog2(POLL_PERIOD), half counter is $clog2(2*HALF_PERIOD), bit index is 4 bits, debounce count is $clog2(DEBOUNCE_POLLS+1).

Decomposition:
- Shared package:
  - FSM state encoding;
  - SNES bit indices (SNES_B=0, SNES_UP=4, …, SNES_A=8);
  - input_data field indices (BTN_UP=0 … BTN_ATTACK=4);
  - PRESSED_LSB=5, RELEASED_LSB=0.
- One sub-module, snes_shift_reader, handles the latch/clock/sample protocol. It outputs raw[15:0] plus a one-cycle raw_valid.
- The top level holds the polling timer, mapping, debounce and edge generation.

Test Plan:
All tests use HALF_PERIOD=2, POLL_PERIOD=200, DEBOUNCE_POLLS=2, with a pad model that shifts on ctrl_clk rising edges.
1. Reset then idle pad (all 16 bits high except raw[15:12]=0) -> ctrl_latch high 4 cycles, 16 ctrl_clk low pulses of 2 cycles each, poll_done every 200 cycles, ctrl_present=1, input_data=0 throughout.
2. Hold Up (raw[4]) for 3 polls -> input_data=10'b00001_00000 for exactly one cycle, on poll_done of the 2nd poll. No pulse on the 1st or 3rd poll.
3. Release Up after it is stable -> input_data=10'b00000_00001 one cycle, on the 2nd poll after release.
4. Press A for one poll only, then release -> no pulses. Press B and A together for 2 polls -> attack press pulse 10'b10000_00000 once.
5. Same poll: Left newly stable pressed and Right newly stable released -> input_data=10'b00100_01000 in a single cycle.
6. Pull ctrl_data low constantly (pad absent) while Up is stable -> ctrl_present=0 and Up release pulse after 2 polls. Assert reset mid-SHIFT -> ctrl_clk=1 and ctrl_latch=0 immediately, input_data=0, and the next poll starts 1 cycle after reset deassertion.

Source files
------------

// File: rtl/controller_input_pkg.sv
// Shared types and constants for the gamepad input path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package controller_input_pkg;

    // Serial reader FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_EVAL     = 3'd4
    } rd_state_t;

    // SNES serial bit positions (after inversion to active-high)
    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;
    localparam int SNES_ID_LSB = 12;
    localparam int SNES_BITS   = 16;

    // Button positions inside each 5-bit field of input_data
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_ATTACK = 4;
    localparam int BTN_W      = 5;

    localparam int PRESSED_LSB  = 5;
    localparam int RELEASED_LSB = 0;

    // Fold the 16 raw pad bits down to the five buttons the player uses
    function automatic logic [BTN_W-1:0] map_buttons(input logic [SNES_BITS-1:0] raw);
        logic [BTN_W-1:0] m;
        m             = '0;
        m[BTN_UP]     = raw[SNES_UP];
        m[BTN_DOWN]   = raw[SNES_DOWN];
        m[BTN_LEFT]   = raw[SNES_LEFT];
        m[BTN_RIGHT]  = raw[SNES_RIGHT];
        m[BTN_ATTACK] = raw[SNES_B] | raw[SNES_A];
        return m;
    endfunction

    // A real pad drives its four ID bits high on the wire (zero once inverted);
    // a floating or shorted line reads them as pressed.
    function automatic logic pad_present(input logic [SNES_BITS-1:0] raw);
        return (raw[SNES_BITS-1:SNES_ID_LSB] == 4'b0000);
    endfunction

endpackage

// File: rtl/controller_input_shift_reader.sv
// Drives the SNES latch/clock protocol and shifts in 16 button bits per poll.
// Latency: 2*HALF_PERIOD*17 + 1 cycles from start to raw_valid.
// Backpressure: none; start is ignored unless the reader is idle.
module snes_shift_reader
    import controller_input_pkg::*;
#(
    parameter int HALF_PERIOD = 150
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ctrl_data,
    output logic                 ctrl_latch,
    output logic                 ctrl_clk,
    output logic [SNES_BITS-1:0] raw,
    output logic                 raw_valid
);

    localparam int HC_W = $clog2(2 * HALF_PERIOD);
    localparam logic [HC_W-1:0] LATCH_LAST = HC_W'(2 * HALF_PERIOD - 1);
    localparam logic [HC_W-1:0] HALF_LAST  = HC_W'(HALF_PERIOD - 1);
    localparam logic [HC_W-1:0] HC_ONE     = HC_W'(1);
    localparam logic [3:0]      LAST_BIT   = 4'd15;

    rd_state_t       state;
    rd_state_t       state_next;
    logic [HC_W-1:0] half_cnt;
    logic [3:0]      bit_idx;
    logic            phase_last;

    // Next-state decode; phase_last marks the final cycle of the current phase
    always_comb begin
        state_next = state;
        raw_valid  = 1'b0;
        phase_last = (state == ST_LATCH) ? (half_cnt == LATCH_LAST)
                                         : (half_cnt == HALF_LAST);
        case (state)
            ST_IDLE:     if (start) state_next = ST_LATCH;
            ST_LATCH:    if (phase_last) state_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (phase_last) state_next = ST_SHIFT_HI;
            ST_SHIFT_HI: if (phase_last) state_next = (bit_idx == LAST_BIT) ? ST_EVAL : ST_SHIFT_LO;
            ST_EVAL: begin
                raw_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    // State register, phase timer, bit capture and registered pad strobes.
    // Pad data is sampled at the end of a phase, well after the pad has shifted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            half_cnt   <= '0;
            bit_idx    <= '0;
            raw        <= '0;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b1;
        end else begin
            state      <= state_next;
            ctrl_latch <= (state_next == ST_LATCH);
            ctrl_clk   <= (state_next != ST_SHIFT_LO);

            if (state_next != state || state == ST_IDLE) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + HC_ONE;
            end

            if (state == ST_IDLE && start) begin
                raw <= '0;
            end

            if (state == ST_LATCH && phase_last) begin
                bit_idx <= '0;
                raw[0]  <= ~ctrl_data;
            end

            if (state == ST_SHIFT_HI && phase_last && bit_idx != LAST_BIT) begin
                bit_idx               <= bit_idx + 4'd1;
                raw[bit_idx + 4'd1]   <= ~ctrl_data;
            end
        end
    end

endmodule

// File: rtl/controller_input.sv
// Polls a SNES pad, debounces five buttons and emits pressed/released pulses.
// Latency: pulses appear the cycle after the EVAL cycle of the poll that settles debounce.
// Backpressure: none; pulses and poll_done are single-cycle and must be consumed on sight.
module controller_input
    import controller_input_pkg::*;
#(
    parameter int HALF_PERIOD    = 150,
    parameter int POLL_PERIOD    = 25000,
    parameter int DEBOUNCE_POLLS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    output logic [9:0] input_data,
    output logic       ctrl_present,
    output logic       poll_done
);

    localparam int PC_W = $clog2(POLL_PERIOD);
    localparam int DB_W = $clog2(DEBOUNCE_POLLS + 1);
    localparam logic [PC_W-1:0] POLL_RELOAD = PC_W'(POLL_PERIOD - 1);
    localparam logic [PC_W-1:0] PC_ONE      = PC_W'(1);
    localparam logic [DB_W-1:0] DB_MAX      = DB_W'(DEBOUNCE_POLLS);
    localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);

    logic [PC_W-1:0]      poll_cnt;
    logic                 poll_start;
    logic [SNES_BITS-1:0] raw;
    logic                 raw_valid;

    logic [BTN_W-1:0] stable;
    logic [BTN_W-1:0] candidate;
    logic [DB_W-1:0]  db_cnt;

    logic             present;
    logic [BTN_W-1:0] sample;
    logic [BTN_W-1:0] cand_next;
    logic [DB_W-1:0]  cnt_next;
    logic [BTN_W-1:0] stable_next;
    logic [9:0]       edge_word;

    assign poll_start = (poll_cnt == '0);

    // Free-running poll timer: zero after reset so the first poll starts immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt <= '0;
        end else if (poll_start) begin
            poll_cnt <= POLL_RELOAD;
        end else begin
            poll_cnt <= poll_cnt - PC_ONE;
        end
    end

    snes_shift_reader #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_reader (
        .clk        (clk),
        .reset      (reset),
        .start      (poll_start),
        .ctrl_data  (ctrl_data),
        .ctrl_latch (ctrl_latch),
        .ctrl_clk   (ctrl_clk),
        .raw        (raw),
        .raw_valid  (raw_valid)
    );

    // Map, presence gate, debounce step and edge extraction for the finished poll
    always_comb begin
        present   = pad_present(raw);
        sample    = present ? map_buttons(raw) : '0;
        cand_next = candidate;
        cnt_next  = db_cnt;
        if (sample == candidate) begin
            if (db_cnt != DB_MAX) begin
                cnt_next = db_cnt + DB_ONE;
            end
        end else begin
            cand_next = sample;
            cnt_next  = DB_ONE;
        end
        stable_next = (cnt_next == DB_MAX) ? cand_next : stable;
        edge_word   = '0;
        edge_word[PRESSED_LSB  +: BTN_W] = stable_next & ~stable;
        edge_word[RELEASED_LSB +: BTN_W] = ~stable_next & stable;
    end

    // Commit debounce state and pulse outputs on the EVAL cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable       <= '0;
            candidate    <= '0;
            db_cnt       <= '0;
            input_data   <= '0;
            ctrl_present <= 1'b0;
            poll_done    <= 1'b0;
        end else begin
            poll_done <= raw_valid;
            if (raw_valid) begin
                stable       <= stable_next;
                candidate    <= cand_next;
                db_cnt       <= cnt_next;
                input_data   <= edge_word;
                ctrl_present <= present;
            end else begin
                input_data   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_controller_input.sv
module tb_controller_input;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl_data;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic [9:0] input_data;
    logic       ctrl_present;
    logic       poll_done;

    controller_input #(
        .HALF_PERIOD    (2),
        .POLL_PERIOD    (200),
        .DEBOUNCE_POLLS (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_data    (ctrl_data),
        .ctrl_latch   (ctrl_latch),
        .ctrl_clk     (ctrl_clk),
        .input_data   (input_data),
        .ctrl_present (ctrl_present),
        .poll_done    (poll_done)
    );

    always #5 clk = ~clk;

    // Active-high button image in SNES bit order; bits 15:12 stay 0 (pad ID lines high)
    localparam logic [15:0] P_UP    = 16'h0010;
    localparam logic [15:0] P_LEFT  = 16'h0040;
    localparam logic [15:0] P_RIGHT = 16'h0080;
    localparam logic [15:0] P_B     = 16'h0001;
    localparam logic [15:0] P_A     = 16'h0100;

    logic [15:0] btn = '0;
    logic        pad_absent = 1'b0;
    int          pad_idx = 0;

    // Pad model: latch presents bit 0, each ctrl_clk rising edge shifts the next bit out
    always @(posedge ctrl_latch) pad_idx = 0;
    always @(posedge ctrl_clk) if (!ctrl_latch) pad_idx = pad_idx + 1;
    assign ctrl_data = pad_absent ? 1'b0 : ((pad_idx < 16) ? ~btn[pad_idx[3:0]] : 1'b1);

    int cyc = 0;
    int n_lat = 0, n_fall = 0, n_low = 0, n_stray = 0;
    logic prev_cc = 1'b1;

    always @(posedge clk) cyc = cyc + 1;

    // Protocol activity counters and pulses seen outside a poll_done cycle
    always @(negedge clk) begin
        if (ctrl_latch) n_lat = n_lat + 1;
        if (ctrl_clk === 1'b0) n_low = n_low + 1;
        if (prev_cc === 1'b1 && ctrl_clk === 1'b0) n_fall = n_fall + 1;
        prev_cc = ctrl_clk;
        if (reset === 1'b1 && input_data != 10'd0 && poll_done !== 1'b1) n_stray = n_stray + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_poll(output logic [9:0] d, output logic pres, output int at);
        bit got;
        got  = 1'b0;
        d    = '0;
        pres = 1'b0;
        at   = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (poll_done === 1'b1) begin
                got  = 1'b1;
                d    = input_data;
                pres = ctrl_present;
                at   = cyc;
            end
        end
        if (!got) check("poll_timeout", 32'd0, 32'd1);
    endtask

    task automatic poll_chk(input string tag, input logic [15:0] b, input logic [9:0] exp_d, input logic exp_p);
        logic [9:0] d;
        logic       p;
        int         t;
        btn = b;
        wait_poll(d, p, t);
        check({tag, "_data"}, {22'd0, d}, {22'd0, exp_d});
        check({tag, "_pres"}, {31'd0, p}, {31'd0, exp_p});
    endtask

    task automatic wait_level(input string tag, input bit want_latch, input logic lvl);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (want_latch ? (ctrl_latch === lvl) : (ctrl_clk === lvl && ctrl_latch === 1'b0)) hit = 1'b1;
        end
        if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [9:0] d;
        logic       p;
        int         t1, t2;
        int         lat0, fall0, low0;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_latch",   {31'd0, ctrl_latch},   32'd0);
        check("rst_clk",     {31'd0, ctrl_clk},     32'd1);
        check("rst_data",    {22'd0, input_data},   32'd0);
        check("rst_present", {31'd0, ctrl_present}, 32'd0);
        check("rst_done",    {31'd0, poll_done},    32'd0);

        lat0  = n_lat;
        fall0 = n_fall;
        low0  = n_low;
        reset = 1'b1;
        @(negedge clk);
        check("first_poll_start", {31'd0, ctrl_latch}, 32'd1);

        // Idle pad: protocol shape and period
        wait_poll(d, p, t1);
        check("latch_cycles", n_lat - lat0,  32'd4);
        check("clk_pulses",   n_fall - fall0, 32'd16);
        check("clk_low_cyc",  n_low - low0,  32'd32);
        check("idle1_data",   {22'd0, d}, 32'd0);
        check("idle1_pres",   {31'd0, p}, 32'd1);
        wait_poll(d, p, t2);
        check("poll_period",  t2 - t1, 32'd200);
        check("idle2_data",   {22'd0, d}, 32'd0);

        // Up press / hold / release
        poll_chk("up_p1", P_UP, 10'b00000_00000, 1'b1);
        poll_chk("up_p2", P_UP, 10'b00001_00000, 1'b1);
        poll_chk("up_p3", P_UP, 10'b00000_00000, 1'b1);
        poll_chk("up_r1", '0,   10'b00000_00000, 1'b1);
        poll_chk("up_r2", '0,   10'b00000_00001, 1'b1);

        // Single-poll glitch on A, then B+A held
        poll_chk("a_glitch", P_A,       10'b00000_00000, 1'b1);
        poll_chk("a_gone",   '0,        10'b00000_00000, 1'b1);
        poll_chk("ba_1",     P_B | P_A, 10'b00000_00000, 1'b1);
        poll_chk("ba_2",     P_B | P_A, 10'b10000_00000, 1'b1);
        poll_chk("ba_r1",    '0,        10'b00000_00000, 1'b1);
        poll_chk("ba_r2",    '0,        10'b00000_10000, 1'b1);

        // Right stable, then Left replaces it in one settling poll
        poll_chk("rt_1", P_RIGHT, 10'b00000_00000, 1'b1);
        poll_chk("rt_2", P_RIGHT, 10'b01000_00000, 1'b1);
        poll_chk("lr_1", P_LEFT,  10'b00000_00000, 1'b1);
        poll_chk("lr_2", P_LEFT,  10'b00100_01000, 1'b1);
        poll_chk("ul_1", P_UP,    10'b00000_00000, 1'b1);
        poll_chk("ul_2", P_UP,    10'b00001_00100, 1'b1);

        // Pad unplugged while Up is stable
        pad_absent = 1'b1;
        poll_chk("absent_1", P_UP, 10'b00000_00000, 1'b0);
        poll_chk("absent_2", P_UP, 10'b00000_00001, 1'b0);
        pad_absent = 1'b0;

        // Reset in the middle of shifting, with Up held across it
        btn = P_UP;
        wait_level("wait_latch", 1'b1, 1'b1);
        wait_level("wait_shift", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_clk",   {31'd0, ctrl_clk},   32'd1);
        check("midrst_latch", {31'd0, ctrl_latch}, 32'd0);
        check("midrst_data",  {22'd0, input_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_restart", {31'd0, ctrl_latch}, 32'd1);
        poll_chk("held_1", P_UP, 10'b00000_00000, 1'b1);
        poll_chk("held_2", P_UP, 10'b00001_00000, 1'b1);

        check("stray_pulses", n_stray, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
